// File: rtl/btb_pkg.sv
// Shared definitions for the two-way branch target buffer.
//   ctr_e       : 2-bit saturating direction counter encoding
//   tag_width   : stored tag width for a given address/index width
//   entry_width : packed width of one way entry (valid, tag, target, counter)
//   ctr_taken   : predicted direction of a counter state
// The entry layout is parametrised by PC/IDX. A package cannot take
// parameters, so the layout is described here by its width functions. Each
// instantiating module declares the matching packed struct.
package btb_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   localparam int PC_DEFAULT  = 32;
   localparam int IDX_DEFAULT = 5;
   localparam int NUM_WAYS    = 2;
   localparam int CTR_W       = 2;

   // Entry layout, MSB to LSB: valid | tag[TAGW] | target[PC] | ctr[2]
   function automatic int tag_width(input int pc_w, input int idx_w);
      return pc_w - idx_w - 2;
   endfunction

   function automatic int entry_width(input int pc_w, input int idx_w);
      return 1 + tag_width(pc_w, idx_w) + pc_w + CTR_W;
   endfunction

   // Both taken states have the MSB set.
   function automatic logic ctr_taken(input ctr_e c);
      return c[1];
   endfunction

endpackage

// File: rtl/btb_2way_if.sv
// Lookup and update bus of the branch target buffer.
//   master : fetch/execute side. Drives the lookup address, flush and the
//            resolved-branch update. Receives the prediction.
//   slave  : the BTB itself.
// Ports:
//   flush_in         : clear all valid bits
//   fetch_pc_in      : lookup address
//   hit_out          : lookup matched a valid entry
//   taken_out        : matched entry predicts taken
//   target_out       : matched entry target, 0 on miss
//   update_in        : resolved-branch update strobe
//   update_pc_in     : address of the resolved branch
//   update_target_in : resolved target
//   update_taken_in  : resolved direction
interface btb_2way_if #(
   parameter int PC = 32
);
   logic          flush_in;
   logic [PC-1:0] fetch_pc_in;
   logic          hit_out;
   logic          taken_out;
   logic [PC-1:0] target_out;
   logic          update_in;
   logic [PC-1:0] update_pc_in;
   logic [PC-1:0] update_target_in;
   logic          update_taken_in;

   modport master (
      output flush_in, fetch_pc_in, update_in, update_pc_in,
             update_target_in, update_taken_in,
      input  hit_out, taken_out, target_out
   );

   modport slave (
      input  flush_in, fetch_pc_in, update_in, update_pc_in,
             update_target_in, update_taken_in,
      output hit_out, taken_out, target_out
   );
endinterface

// File: rtl/btb_sat_ctr.sv
// Next-state logic of the 2-bit saturating direction counter.
//   state_i : current counter state
//   taken_i : resolved direction (1 = count up, 0 = count down)
//   next_o  : next counter state, saturating at STRONG_NT / STRONG_T
module btb_sat_ctr
   import btb_pkg::*;
(
   input  ctr_e state_i,
   input  logic taken_i,
   output ctr_e next_o
);

   always_comb begin
      next_o = state_i;
      unique case (state_i)
         STRONG_NT: next_o = taken_i ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   next_o = taken_i ? WEAK_T   : STRONG_NT;
         WEAK_T:    next_o = taken_i ? STRONG_T : WEAK_NT;
         STRONG_T:  next_o = taken_i ? STRONG_T : WEAK_T;
         default:   next_o = state_i;
      endcase
   end

endmodule

// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer.
// The lookup is purely combinational from the fetch address. The update
// port trains the table with resolved branches and allocates entries on
// taken misses. Updates become visible on the cycle after the strobe.
// Ports:
//   clk_in : clock, all state changes on the rising edge
//   rst_in : synchronous active-high reset
//   bus    : btb_2way_if slave (flush, lookup, update)
module btb_2way
   import btb_pkg::*;
#(
   parameter int PC  = PC_DEFAULT,
   parameter int IDX = IDX_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   btb_2way_if.slave   bus
);

   localparam int TAGW = tag_width(PC, IDX);
   localparam int SETS = 1 << IDX;

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      logic [PC-1:0]   target;
      ctr_e            ctr;
   } entry_t;

   // Flip-flop storage: [way][set]
   entry_t            entry_q [NUM_WAYS][SETS];
   // Per set: the way to replace next
   logic [SETS-1:0]   lru_q;

   // ---------------- lookup ----------------
   logic [IDX-1:0]      f_idx;
   logic [TAGW-1:0]     f_tag;
   logic [NUM_WAYS-1:0] f_way_hit;
   logic                f_sel;
   entry_t              f_entry;

   assign f_idx = bus.fetch_pc_in[IDX+1:2];
   assign f_tag = bus.fetch_pc_in[PC-1:IDX+2];

   // ---------------- update ----------------
   logic [IDX-1:0]      u_idx;
   logic [TAGW-1:0]     u_tag;
   logic [NUM_WAYS-1:0] u_way_hit;
   logic                u_hit;
   logic                u_hit_way;
   logic                alloc_way;
   logic                wr_way;
   logic                wr_en;
   ctr_e                u_ctr;
   ctr_e                u_ctr_next;
   entry_t              wr_entry_d;

   assign u_idx = bus.update_pc_in[IDX+1:2];
   assign u_tag = bus.update_pc_in[PC-1:IDX+2];

   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_cmp
      assign f_way_hit[gi] = entry_q[gi][f_idx].valid &&
                             (entry_q[gi][f_idx].tag == f_tag);
      assign u_way_hit[gi] = entry_q[gi][u_idx].valid &&
                             (entry_q[gi][u_idx].tag == u_tag);
   end

   // Way 0 takes priority if both ways hit. That only happens if the table
   // was corrupted, but the result must still be deterministic.
   assign f_sel   = f_way_hit[0] ? 1'b0 : 1'b1;
   assign f_entry = entry_q[f_sel][f_idx];

   assign bus.hit_out    = |f_way_hit;
   assign bus.taken_out  = (|f_way_hit) && ctr_taken(f_entry.ctr);
   assign bus.target_out = (|f_way_hit) ? f_entry.target : '0;

   assign u_hit     = |u_way_hit;
   assign u_hit_way = u_way_hit[0] ? 1'b0 : 1'b1;

   // Fill an empty way first (way 0 before way 1). Evict the LRU way only
   // when the set is full.
   always_comb begin
      alloc_way = lru_q[u_idx];
      if (!entry_q[0][u_idx].valid) begin
         alloc_way = 1'b0;
      end else if (!entry_q[1][u_idx].valid) begin
         alloc_way = 1'b1;
      end
   end

   assign wr_way = u_hit ? u_hit_way : alloc_way;
   // A not-taken miss leaves the table untouched.
   assign wr_en  = bus.update_in && (u_hit || bus.update_taken_in);
   assign u_ctr  = entry_q[u_hit_way][u_idx].ctr;

   btb_sat_ctr u_sat_ctr (
      .state_i (u_ctr),
      .taken_i (bus.update_taken_in),
      .next_o  (u_ctr_next)
   );

   always_comb begin
      wr_entry_d = entry_q[u_hit_way][u_idx];
      if (u_hit) begin
         wr_entry_d.ctr = u_ctr_next;
         // Keep the last known target when the branch falls through.
         if (bus.update_taken_in) begin
            wr_entry_d.target = bus.update_target_in;
         end
      end else begin
         wr_entry_d.valid  = 1'b1;
         wr_entry_d.tag    = u_tag;
         wr_entry_d.target = bus.update_target_in;
         wr_entry_d.ctr    = WEAK_T;
      end
   end

   // Priority: reset > flush > update. A dropped update leaves no trace.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               entry_q[w][s].valid <= 1'b0;
               entry_q[w][s].ctr   <= WEAK_NT;
            end
         end
         lru_q <= '0;
      end else if (bus.flush_in) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               entry_q[w][s].valid <= 1'b0;
            end
         end
      end else if (wr_en) begin
         entry_q[wr_way][u_idx] <= wr_entry_d;
         lru_q[u_idx]           <= ~wr_way;
      end
   end

   // Byte-offset bits take no part in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{bus.fetch_pc_in[1:0], bus.update_pc_in[1:0]};

endmodule

// File: tb/tb_btb_2way.sv
// Scoreboard bench for btb_2way (PC=32, IDX=5).
// The driver issues one cycle per call. When that cycle carries a lookup,
// the driver pushes the hand-computed prediction into exp_q. The monitor
// samples on the falling edge, pops one entry and compares it.
module tb_btb_2way;

   logic clk;
   logic rst;
   logic lookup_req;

   btb_2way_if #(.PC(32)) bus ();

   btb_2way #(.PC(32), .IDX(5)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   typedef struct {
      string       name;
      logic        hit;
      logic        tk;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compares the DUT prediction against the oldest expectation.
   always @(negedge clk) begin
      if (lookup_req) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got hit=%0b with no expected entry", bus.hit_out);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (bus.hit_out !== e.hit || bus.taken_out !== e.tk || bus.target_out !== e.tgt) begin
               errors++;
               $display("FAIL %s: got hit=%0b taken=%0b target=%h, expected hit=%0b taken=%0b target=%h",
                        e.name, bus.hit_out, bus.taken_out, bus.target_out, e.hit, e.tk, e.tgt);
            end else begin
               $display("%0t %s: hit=%0b taken=%0b target=%h ok",
                        $time, e.name, bus.hit_out, bus.taken_out, bus.target_out);
            end
         end
      end
   end

   task automatic cyc(input bit rs, input bit fl, input bit up,
                      input logic [31:0] upc, input logic [31:0] utgt, input bit utk,
                      input bit lk, input logic [31:0] fpc,
                      input bit eh, input bit et, input logic [31:0] etgt,
                      input string nm);
      exp_t e;
      rst                  = rs;
      bus.flush_in         = fl;
      bus.update_in        = up;
      bus.update_pc_in     = upc;
      bus.update_target_in = utgt;
      bus.update_taken_in  = utk;
      bus.fetch_pc_in      = fpc;
      lookup_req           = lk;
      if (lk) begin
         e.name = nm;
         e.hit  = eh;
         e.tk   = et;
         e.tgt  = etgt;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
      cyc(0, 0, 1, pc, tgt, tk, 0, 32'h0, 0, 0, 32'h0, "");
   endtask

   task automatic look(input logic [31:0] pc, input bit eh, input bit et,
                       input logic [31:0] etgt, input string nm);
      cyc(0, 0, 0, 32'h0, 32'h0, 0, 1, pc, eh, et, etgt, nm);
   endtask

   // Watchdog: the stimulus is straight-line, so this only trips if time stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                  = 1'b1;
      lookup_req           = 1'b0;
      bus.flush_in         = 1'b0;
      bus.update_in        = 1'b0;
      bus.update_pc_in     = '0;
      bus.update_target_in = '0;
      bus.update_taken_in  = 1'b0;
      bus.fetch_pc_in      = '0;
      @(posedge clk);
      #1;

      // Reset hold and first lookup
      cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_1000, 0, 0, 32'h0, "rst_hold");
      look(32'h0000_1000, 0, 0, 32'h0, "after_rst_miss");

      // Allocation: the same-cycle lookup sees the old contents
      cyc(0, 0, 1, 32'h0000_1000, 32'h0000_2000, 1, 1, 32'h0000_1000, 0, 0, 32'h0, "same_cycle_miss");
      look(32'h0000_1000, 1, 1, 32'h0000_2000, "alloc_hit");

      // Counter down from WEAK_T. A not-taken update keeps the target.
      upd(32'h0000_1000, 32'hDEAD_0000, 0);
      look(32'h0000_1000, 1, 0, 32'h0000_2000, "nt1_weak_nt");
      upd(32'h0000_1000, 32'hDEAD_0000, 0);
      look(32'h0000_1000, 1, 0, 32'h0000_2000, "nt2_strong_nt");
      upd(32'h0000_1000, 32'hDEAD_0000, 0);
      look(32'h0000_1000, 1, 0, 32'h0000_2000, "nt3_floor_sat");

      // Counter up from STRONG_NT. A taken update overwrites the target.
      upd(32'h0000_1000, 32'h0000_2004, 1);
      look(32'h0000_1000, 1, 0, 32'h0000_2004, "t1_weak_nt");
      upd(32'h0000_1000, 32'h0000_2008, 1);
      look(32'h0000_1000, 1, 1, 32'h0000_2008, "t2_weak_t");
      upd(32'h0000_1000, 32'h0000_200C, 1);
      look(32'h0000_1000, 1, 1, 32'h0000_200C, "t3_strong_t");
      upd(32'h0000_1000, 32'h0000_2010, 1);
      look(32'h0000_1000, 1, 1, 32'h0000_2010, "t4_ceiling_sat");
      upd(32'h0000_1000, 32'h0, 0);
      look(32'h0000_1000, 1, 1, 32'h0000_2010, "st_to_wt");
      upd(32'h0000_1000, 32'h0, 0);
      look(32'h0000_1000, 1, 0, 32'h0000_2010, "wt_to_wnt");

      // Not-taken miss does not allocate
      upd(32'h0000_3000, 32'h0000_4000, 0);
      look(32'h0000_3000, 0, 0, 32'h0, "nt_no_alloc");
      look(32'h0000_1000, 1, 0, 32'h0000_2010, "set0_intact");

      // Flush with a simultaneous update: the update is dropped
      cyc(0, 1, 1, 32'h0000_1080, 32'h0000_3080, 1, 1, 32'h0000_1000, 1, 0, 32'h0000_2010, "flush_cycle_pre");
      look(32'h0000_1000, 0, 0, 32'h0, "flush_miss");
      look(32'h0000_1080, 0, 0, 32'h0, "flush_drop_upd");

      // Fill set 0 (way 0 first), then evict the LRU way
      upd(32'h0000_1000, 32'h0000_5000, 1);
      upd(32'h0000_1080, 32'h0000_5080, 1);
      upd(32'h0000_1100, 32'h0000_5100, 1);
      look(32'h0000_1000, 0, 0, 32'h0, "evict_lru_miss");
      look(32'h0000_1080, 1, 1, 32'h0000_5080, "evict_keep_1080");
      look(32'h0000_1100, 1, 1, 32'h0000_5100, "evict_new_1100");

      // The lookups above must not have moved LRU off way 1 (0x1080)
      upd(32'h0000_1180, 32'h0000_5180, 1);
      look(32'h0000_1080, 0, 0, 32'h0, "lookup_no_lru_miss");
      look(32'h0000_1100, 1, 1, 32'h0000_5100, "lookup_no_lru_keep");
      look(32'h0000_1180, 1, 1, 32'h0000_5180, "lookup_no_lru_new");

      // An update hit on way 0 points LRU at way 1 (0x1180)
      upd(32'h0000_1100, 32'h0000_5104, 1);
      upd(32'h0000_1200, 32'h0000_5200, 1);
      look(32'h0000_1180, 0, 0, 32'h0, "hit_lru_evicted");
      look(32'h0000_1100, 1, 1, 32'h0000_5104, "hit_lru_keep");
      look(32'h0000_1200, 1, 1, 32'h0000_5200, "hit_lru_new");

      // Top of the address space: last set, full-width tag
      upd(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
      look(32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFC, "wrap_hit_lowbits");
      look(32'h7FFF_FFFC, 0, 0, 32'h0, "wrap_tag_msb");

      // Reset beats a simultaneous flush and update
      cyc(1, 1, 1, 32'h0000_1004, 32'h0000_6000, 1, 0, 32'h0, 0, 0, 32'h0, "");
      cyc(1, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_1100, 0, 0, 32'h0, "rst_hold2");
      look(32'h0000_1100, 0, 0, 32'h0, "rst_clears_1100");
      look(32'h0000_1004, 0, 0, 32'h0, "rst_drop_upd");
      look(32'hFFFF_FFFC, 0, 0, 32'h0, "rst_clears_wrap");

      // After reset, a fresh allocation starts at WEAK_T
      upd(32'h0000_1004, 32'h0000_6000, 1);
      look(32'h0000_1004, 1, 1, 32'h0000_6000, "post_rst_alloc");
      upd(32'h0000_1004, 32'h0000_6000, 0);
      look(32'h0000_1004, 1, 0, 32'h0000_6000, "post_rst_weak_nt");

      cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, "");
      cyc(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, "");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
